// File: rtl/window_scan_ctrl.sv
// Serpentine scan controller feeding a 7x7 window buffer from pixel memory.
// Define WINDOW_PREFETCH_EN to fetch the next slice while waiting for window_ack.
module window_scan_ctrl #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              shift_enable,
    output logic [1:0]        shift_direction,
    output logic [0:6][7:0]   buffer_input,
    output logic              window_valid,
    input  logic              window_ack,
    output logic [15:0]       window_x,
    output logic [15:0]       window_y,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_WAIT_ACK, S_DONE} state_t;

    localparam logic [31:0] IMG_W_U = 32'(IMG_W);
    localparam logic [15:0] X_LAST  = 16'(IMG_W - 7);
    localparam logic [15:0] Y_LAST  = 16'(IMG_H - 7);

    state_t              state_r, state_n;
    logic [3:0]          cnt_r, cnt_n;      // 0..6 issue, 1..7 capture, 8 = idle fetcher
    logic [2:0]          prime_r, prime_n;
    logic [15:0]         x_r, x_n, y_r, y_n;
    logic                right_r, right_n;
    logic [ADDR_W-1:0]   base_r, base_n;
    logic                row_r, row_n;
    logic [1:0]          dir_r, dir_n;
    logic [0:6][7:0]     staging_r, staging_n;

    logic                mem_ren_n, shift_enable_n, window_valid_n, busy_n, done_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [1:0]          shift_direction_n;
    logic [0:6][7:0]     buffer_input_n;

    logic                at_end_s, last_s, adv_right_s, adv_row_s;
    logic [15:0]         adv_x_s, adv_y_s;
    logic [1:0]          adv_dir_s;
    logic [31:0]         adv_base_s;
    logic [2:0]          cap_idx_s;

    function automatic logic [ADDR_W-1:0] slice_addr(input logic [ADDR_W-1:0] base,
                                                     input logic row, input logic [3:0] k);
        logic [31:0] a;
        if (row) begin
            a = 32'(base) + 32'(k);
        end else begin
            a = 32'(base) + 32'(k) * IMG_W_U;
        end
        return a[ADDR_W-1:0];
    endfunction

    // Next cursor and the slice that advancing to it requires.
    always_comb begin
        at_end_s    = right_r ? (x_r == X_LAST) : (x_r == 16'd0);
        last_s      = (y_r == Y_LAST) && at_end_s;
        adv_x_s     = x_r;
        adv_y_s     = y_r;
        adv_right_s = right_r;
        adv_row_s   = 1'b0;
        adv_dir_s   = 2'b01;
        if (at_end_s) begin
            adv_y_s     = y_r + 16'd1;
            adv_row_s   = 1'b1;
            adv_dir_s   = 2'b11;
            adv_right_s = ~right_r;
            adv_base_s  = (32'(adv_y_s) + 32'd6) * IMG_W_U + 32'(x_r);
        end else if (right_r) begin
            adv_x_s    = x_r + 16'd1;
            adv_base_s = 32'(y_r) * IMG_W_U + 32'(adv_x_s) + 32'd6;
        end else begin
            adv_x_s    = x_r - 16'd1;
            adv_dir_s  = 2'b10;
            adv_base_s = 32'(y_r) * IMG_W_U + 32'(adv_x_s);
        end
    end

    // Next-state, fetch sequencing and next output values.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        prime_n   = prime_r;
        x_n       = x_r;
        y_n       = y_r;
        right_n   = right_r;
        base_n    = base_r;
        row_n     = row_r;
        dir_n     = dir_r;
        staging_n = staging_r;
        cap_idx_s = cnt_r[2:0] - 3'd1;

        if ((state_r == S_FETCH || state_r == S_WAIT_ACK) && cnt_r != 4'd0 && cnt_r <= 4'd7) begin
            staging_n[cap_idx_s] = mem_rdata;
        end else begin
            staging_n = staging_r;
        end

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    cnt_n   = 4'd0;
                    prime_n = 3'd0;
                    x_n     = 16'd0;
                    y_n     = 16'd0;
                    right_n = 1'b1;
                    base_n  = {ADDR_W{1'b0}};
                    row_n   = 1'b0;
                    dir_n   = 2'b01;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_FETCH: begin
                cnt_n = cnt_r + 4'd1;
                if (cnt_r == 4'd7) begin
                    state_n = S_SHIFT;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_SHIFT: begin
                if (prime_r < 3'd6) begin
                    prime_n = prime_r + 3'd1;
                    state_n = S_FETCH;
                    cnt_n   = 4'd0;
                    base_n  = {{(ADDR_W-3){1'b0}}, prime_n};
                    row_n   = 1'b0;
                    dir_n   = 2'b01;
                end else begin
                    prime_n = 3'd7;
                    state_n = S_WAIT_ACK;
                    cnt_n   = 4'd8;
`ifdef WINDOW_PREFETCH_EN
                    if (!last_s) begin
                        cnt_n  = 4'd0;
                        base_n = adv_base_s[ADDR_W-1:0];
                        row_n  = adv_row_s;
                        dir_n  = adv_dir_s;
                    end else begin
                        cnt_n = 4'd8;
                    end
`endif
                end
            end
            S_WAIT_ACK: begin
                if (cnt_r < 4'd8) begin
                    cnt_n = cnt_r + 4'd1;
                end else begin
                    cnt_n = cnt_r;
                end
                if (window_ack) begin
                    if (last_s) begin
                        state_n = S_DONE;
                    end else begin
                        x_n     = adv_x_s;
                        y_n     = adv_y_s;
                        right_n = adv_right_s;
`ifdef WINDOW_PREFETCH_EN
                        state_n = (cnt_r >= 4'd7) ? S_SHIFT : S_FETCH;
`else
                        state_n = S_FETCH;
                        cnt_n   = 4'd0;
                        base_n  = adv_base_s[ADDR_W-1:0];
                        row_n   = adv_row_s;
                        dir_n   = adv_dir_s;
`endif
                    end
                end else begin
                    state_n = S_WAIT_ACK;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        mem_ren_n         = (state_n == S_FETCH || state_n == S_WAIT_ACK) && (cnt_n < 4'd7);
        mem_addr_n        = mem_ren_n ? slice_addr(base_n, row_n, cnt_n) : mem_addr;
        shift_enable_n    = (state_n == S_SHIFT);
        shift_direction_n = shift_enable_n ? dir_n : 2'b00;
        buffer_input_n    = shift_enable_n ? staging_n : buffer_input;
        window_valid_n    = (state_n == S_WAIT_ACK);
        busy_n            = (state_n == S_FETCH) || (state_n == S_SHIFT) || (state_n == S_WAIT_ACK);
        done_n            = (state_n == S_DONE);
    end

    // State, cursor, staging and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r         <= S_IDLE;
            cnt_r           <= 4'd0;
            prime_r         <= 3'd0;
            x_r             <= 16'd0;
            y_r             <= 16'd0;
            right_r         <= 1'b0;
            base_r          <= {ADDR_W{1'b0}};
            row_r           <= 1'b0;
            dir_r           <= 2'b00;
            staging_r       <= '0;
            mem_ren         <= 1'b0;
            mem_addr        <= {ADDR_W{1'b0}};
            shift_enable    <= 1'b0;
            shift_direction <= 2'b00;
            buffer_input    <= '0;
            window_valid    <= 1'b0;
            window_x        <= 16'd0;
            window_y        <= 16'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_r         <= state_n;
            cnt_r           <= cnt_n;
            prime_r         <= prime_n;
            x_r             <= x_n;
            y_r             <= y_n;
            right_r         <= right_n;
            base_r          <= base_n;
            row_r           <= row_n;
            dir_r           <= dir_n;
            staging_r       <= staging_n;
            mem_ren         <= mem_ren_n;
            mem_addr        <= mem_addr_n;
            shift_enable    <= shift_enable_n;
            shift_direction <= shift_direction_n;
            buffer_input    <= buffer_input_n;
            window_valid    <= window_valid_n;
            window_x        <= x_n;
            window_y        <= y_n;
            busy            <= busy_n;
            done            <= done_n;
        end
    end
endmodule
